// File: rtl/led_effect_sequencer_if.sv
// Bus bundle between the user-input block and the LED effect sequencer.
//   btn_next    : advance-effect request (pulse, or raw button with BTN_DEBOUNCE_EN)
//   auto_en     : 1 = auto-advance after a fixed step count
//   hold        : 1 = freeze stepping
//   led         : LED drive, active-low (0 = lit)
//   effect_id   : current effect (0 johnson, 1 rotate, 2 blink, 3 ping-pong)
//   step_strobe : one-cycle pulse when a new stepped LED value appears
// master = control side (drives requests), slave = sequencer side.
interface led_effect_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             btn_next;
  logic             auto_en;
  logic             hold;
  logic [WIDTH-1:0] led;
  logic [1:0]       effect_id;
  logic             step_strobe;

  modport master (
    output btn_next, auto_en, hold,
    input  led, effect_id, step_strobe
  );

  modport slave (
    input  btn_next, auto_en, hold,
    output led, effect_id, step_strobe
  );
endinterface

// File: rtl/led_effect_sequencer.sv
// LED effect sequencer: drives one LED bar with four effects (Johnson,
// rotating dot, blink-all, ping-pong), stepping every TICK_DIV clocks.
// A LOAD/RUN/HOLD FSM loads each effect's initial pattern, advances on a
// button event or (with auto_en) after STEPS_PER_EFFECT steps.
// Ports:
//   clk : system clock
//   rst : synchronous, active-low reset
//   bus : led_effect_sequencer_if.slave (btn_next, auto_en, hold in;
//         led, effect_id, step_strobe out; all outputs registered)
// Optional macro BTN_DEBOUNCE_EN: btn_next is a raw pushbutton passed
// through a 2-flop synchroniser, a DEBOUNCE_CYCLES stability filter and a
// rising-edge detector. Without it, each high cycle of btn_next is one event.
module led_effect_sequencer #(
  parameter int WIDTH            = 8,
  parameter int TICK_DIV         = 13_500_000,
  parameter int STEPS_PER_EFFECT = 16,
  parameter int DEBOUNCE_CYCLES  = 270_000
) (
  input logic                  clk,
  input logic                  rst,
  led_effect_sequencer_if.slave bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STEPS_PER_EFFECT + 1);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0]    STEP_LAST = SW'(STEPS_PER_EFFECT - 1);
  localparam logic [WIDTH-1:0] ALL_OFF   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] DOT_LOW   = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] DOT_HIGH  = {1'b0, {(WIDTH-1){1'b1}}};

  if (WIDTH < 4 || TICK_DIV < 2 || STEPS_PER_EFFECT < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("led_effect_sequencer: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [TW-1:0]    tick_r, tick_s;
  logic [SW-1:0]    step_cnt_r, step_cnt_s;
  logic             dir_r, dir_s;         // ping-pong: 0 = left, 1 = right
  logic [WIDTH-1:0] led_r, led_s, stepped_s;
  logic [1:0]       effect_r, effect_s;
  logic             strobe_r, strobe_s;
  logic             btn_evt_s;

  function automatic logic [WIDTH-1:0] effect_init(input logic [1:0] id);
    case (id)
      2'd0:    effect_init = ALL_OFF;
      2'd1:    effect_init = DOT_LOW;
      2'd2:    effect_init = ALL_OFF;
      2'd3:    effect_init = DOT_LOW;
      default: effect_init = ALL_OFF;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] effect_step(input logic [1:0] id,
                                                   input logic [WIDTH-1:0] cur,
                                                   input logic dir_right);
    case (id)
      2'd0:    effect_step = {~cur[0], cur[WIDTH-1:1]};
      2'd1:    effect_step = {cur[WIDTH-2:0], cur[WIDTH-1]};
      2'd2:    effect_step = ~cur;
      2'd3:    effect_step = dir_right ? {1'b1, cur[WIDTH-1:1]} : {cur[WIDTH-2:0], 1'b1};
      default: effect_step = cur;
    endcase
  endfunction

`ifdef BTN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r, sync2_r, deb_r, btn_evt_r;
  logic [CW-1:0] deb_cnt_r;

  // Synchronise, debounce and edge-detect the raw button.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      deb_r     <= 1'b0;
      btn_evt_r <= 1'b0;
      deb_cnt_r <= {CW{1'b0}};
    end else begin
      sync1_r   <= bus.btn_next;
      sync2_r   <= sync1_r;
      btn_evt_r <= 1'b0;
      if (sync2_r == deb_r) begin
        deb_cnt_r <= {CW{1'b0}};
      end else if (deb_cnt_r == DEB_LAST) begin
        // New level held long enough: accept it; only a press raises an event.
        deb_r     <= sync2_r;
        deb_cnt_r <= {CW{1'b0}};
        btn_evt_r <= sync2_r;
      end else begin
        deb_cnt_r <= deb_cnt_r + 1'b1;
      end
    end
  end

  assign btn_evt_s = btn_evt_r;
`else
  assign btn_evt_s = bus.btn_next;
`endif

  // Next-state and next-value logic for the sequencer FSM.
  always_comb begin
    state_s    = state_r;
    tick_s     = tick_r;
    step_cnt_s = step_cnt_r;
    dir_s      = dir_r;
    led_s      = led_r;
    effect_s   = effect_r;
    strobe_s   = 1'b0;
    stepped_s  = effect_step(effect_r, led_r, dir_r);
    case (state_r)
      ST_LOAD: begin
        led_s      = effect_init(effect_r);
        tick_s     = {TW{1'b0}};
        step_cnt_s = {SW{1'b0}};
        dir_s      = 1'b0;
        if (bus.hold) begin
          state_s = ST_HOLD;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_RUN, ST_HOLD: begin
        // Button wins over hold and over a coinciding tick wrap.
        if (btn_evt_s) begin
          effect_s = effect_r + 2'd1;
          state_s  = ST_LOAD;
        end else if (bus.hold) begin
          state_s = ST_HOLD;
        end else begin
          // Releasing hold resumes counting in the same cycle, so a hold of
          // N cycles delays the next step by exactly N cycles.
          state_s = ST_RUN;
          if (tick_r == TICK_LAST) begin
            tick_s = {TW{1'b0}};
            if (bus.auto_en && step_cnt_r == STEP_LAST) begin
              effect_s = effect_r + 2'd1;
              state_s  = ST_LOAD;
            end else begin
              led_s    = stepped_s;
              strobe_s = 1'b1;
              // Saturate so a late auto_en still advances on the next wrap.
              if (step_cnt_r != STEP_LAST) begin
                step_cnt_s = step_cnt_r + 1'b1;
              end else begin
                step_cnt_s = step_cnt_r;
              end
              if (effect_r == 2'd3 && stepped_s == DOT_HIGH) begin
                dir_s = 1'b1;
              end else if (effect_r == 2'd3 && stepped_s == DOT_LOW) begin
                dir_s = 1'b0;
              end else begin
                dir_s = dir_r;
              end
            end
          end else begin
            tick_s = tick_r + 1'b1;
          end
        end
      end
      default: begin
        state_s = ST_LOAD;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_LOAD;
      tick_r     <= {TW{1'b0}};
      step_cnt_r <= {SW{1'b0}};
      dir_r      <= 1'b0;
      led_r      <= ALL_OFF;
      effect_r   <= 2'd0;
      strobe_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      tick_r     <= tick_s;
      step_cnt_r <= step_cnt_s;
      dir_r      <= dir_s;
      led_r      <= led_s;
      effect_r   <= effect_s;
      strobe_r   <= strobe_s;
    end
  end

  assign bus.led         = led_r;
  assign bus.effect_id   = effect_r;
  assign bus.step_strobe = strobe_r;

endmodule

// File: doc/led_effect_sequencer.md
Name: led_effect_sequencer

Overview:
Controller that owns the board's LED bar and sequences four LED effects on one shared output: Johnson counter, rotating dot, blink-all and ping-pong. It has a built-in step-rate divider and a small control FSM. In auto mode it advances effects after a fixed step count; a button input also advances effects. It sits between the user-input block (button/switches) and the top-level LED pins, and replaces standalone per-effect LED modules.

Parameters:
WIDTH, 8, LED bar width; must be ≥ 4.
TICK_DIV, 13_500_000, clk cycles per effect step; must be ≥ 2.
STEPS_PER_EFFECT, 16, steps an effect runs before auto-advance; must be ≥ 1.
DEBOUNCE_CYCLES, 270_000, stable cycles required on btn (used only with BTN_DEBOUNCE_EN).

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
btn_next  in  1  advance to the next effect; see Optional Feature for its format
auto_en  in  1  1 = auto-advance after STEPS_PER_EFFECT steps
hold  in  1  1 = freeze stepping; LEDs keep their current value
led  out  WIDTH  LED drive, active-low (0 = lit)
effect_id  out  2  current effect: 0 johnson, 1 rotate, 2 blink, 3 ping-pong
step_strobe  out  1  one-cycle pulse in the cycle a new stepped led value first appears

Behaviour:
- Reset (rst=0 at posedge):
  - led = all ones, effect_id = 0, step_strobe = 0.
  - Tick counter = 0, step counter = 0, ping-pong direction = left.
  - FSM = LOAD.
- FSM states: LOAD, RUN, HOLD.
  - LOAD (always 1 cycle): led ← init(effect_id), tick counter ← 0, step counter ← 0, direction ← left. Next state is HOLD if hold=1, otherwise RUN.
  - RUN: tick counter counts 0..TICK_DIV-1.
    - At TICK_DIV-1 the counter wraps to 0, led ← step(effect_id, led), step_strobe = 1 in the following cycle, step counter +1.
    - If auto_en=1 and the step counter equals STEPS_PER_EFFECT-1 at the wrap: no step is applied, effect_id ← effect_id+1 (mod 4), next state LOAD.
    - hold=1 → HOLD; the tick counter retains its value.
  - HOLD: all counters and led frozen. hold=0 → RUN, resuming the tick count where it stopped.
- Effect advance: a qualified btn_next event in RUN or HOLD sets effect_id ← effect_id+1 (wrap 3→0) and goes to LOAD.
  - Latency: event at cycle n → effect_id new at n+1 → led = init at n+2.
  - A btn event in the same cycle as a tick wrap takes priority; the tick is discarded and no step_strobe is produced.
  - A btn event during LOAD is ignored.
- Effect init and step, written for WIDTH=8 and generalised to WIDTH:
  - Johnson: init FF; step {~led[0], led[7:1]}; period 2·WIDTH.
  - Rotate: init FE; step {led[6:0], led[7]}; period WIDTH.
  - Blink: init FF; step ~led; period 2.
  - Ping-pong: init FE with direction left.
    - Left: step {led[6:0],1}. Right: step {1,led[7:1]}.
    - Direction flips on the step that produces 7F (bit WIDTH-1 lit) and on the step that produces FE.
    - Sequence: FE,FD,…,7F,BF,…,FE; period 2·WIDTH-2.
- Auto-advance counts steps per effect from LOAD; toggling auto_en mid-effect does not clear the step counter.
- Mid-operation reset: rst=0 takes effect at the next posedge regardless of state, with all values as listed under Reset.

Optional Feature:
Macro BTN_DEBOUNCE_EN.
- Defined: btn_next is a raw asynchronous, active-high pushbutton.
  - Path: 2-flop synchroniser → counter requiring DEBOUNCE_CYCLES consecutive stable samples → rising-edge detect.
  - Exactly one qualified event per press. Added latency is 2 + DEBOUNCE_CYCLES cycles.
  - Debounce state is reset by rst.
- Undefined: btn_next must be a synchronous single-cycle pulse. Each cycle it is high counts as one event, with no filtering.

Test Plan:
1. TICK_DIV=4, STEPS=16, auto_en=0, hold=0; release reset.
   → led=FF; step_strobe every 4 cycles; led sequence FF,7F,3F,…,00,80,…,FE,FF (16 steps, repeats); effect_id stays 0.
2. auto_en=1, TICK_DIV=4, STEPS=4.
   → after 3 steps, the 4th wrap produces LOAD with no strobe; effect_id 0→1, led=FE, then FD,FB,F7; then effect 2 (FF,00,FF,00), effect 3, and wrap to effect 0.
3. Effect 3, TICK_DIV=2: run 16 steps.
   → FE,FD,FB,F7,EF,DF,BF,7F,BF,DF,EF,F7,FB,FD,FE,FD; direction flips exactly at 7F and FE.
4. btn_next pulse coincident with a tick wrap in effect 1.
   → no step_strobe; effect_id=2 next cycle; led=FF one cycle later; tick counter restarts from 0.
5. hold=1 for 10 cycles mid-interval at tick count 2, TICK_DIV=4.
   → led and counters frozen; after hold=0 the next strobe occurs exactly 2 cycles later; a btn pulse during hold gives LOAD then HOLD with led=init.
6. rst=0 asserted during effect 3 RUN; BTN_DEBOUNCE_EN with DEBOUNCE_CYCLES=5: bouncing btn (1,0,1,0 then stable 1).
   → after reset, led=FF and effect_id=0; exactly one advance occurs 7 cycles after the input is stable.
